// File: rtl/seg_scan_controller_if.sv
// Display-value load port: valid/ready handshake carrying one 32-bit value.
// Transfer occurs on any rising clock edge where load_valid && load_ready.
// The source must hold load_valid and load_data stable until load_ready is seen.
//
// Signals:
//   load_valid  source -> sink  new display value offered
//   load_ready  sink -> source  shadow buffer free
//   load_data   source -> sink  eight nibbles, nibble i = digit i (digit 0 rightmost)
interface seg_scan_controller_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;

  // Producer of display values.
  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  // Scan controller side.
  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan sequencer for an 8-digit common-anode 7-segment display.
// Latency: all outputs registered; a loaded value shows from digit 0 of the frame after acceptance.
// Backpressure: load_ready drops while a value is waiting in the shadow buffer and rises after the frame boundary.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   io_load        valid/ready load port for the 32-bit display value
//   i_digit_en     per-digit enable mask, bit i lets digit i light
//   i_brightness   PWM level 0..15, captured at the start of each ON phase
//   o_refresh_idx  current digit slot 0..7
//   o_digit_code   nibble of the active buffer for o_refresh_idx
//   o_anode        active-low anode drive, at most one bit low
//   o_frame_done   one-cycle pulse on the last cycle of digit 7's slot
module seg_scan_controller #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 2000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  seg_scan_controller_if.slave        io_load,
  input  logic [7:0]                  i_digit_en,
  input  logic [3:0]                  i_brightness,
  output logic [2:0]                  o_refresh_idx,
  output logic [3:0]                  o_digit_code,
  output logic [7:0]                  o_anode,
  output logic                        o_frame_done
);

  // BLANK_TICKS must be at least 1 and below TICKS_PER_DIGIT; ON_TICKS >= 16.
  localparam int ON_TICKS = TICKS_PER_DIGIT - BLANK_TICKS;
  localparam int STEP     = ON_TICKS / 16;
  localparam int CW       = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_TICKS - 1);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_t;

  // Sequencer state
  phase_t         r_phase;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_bright;

  // Double buffer
  logic [31:0]    r_active;
  logic [31:0]    r_shadow;
  logic           r_pending;

  // Registered outputs
  logic [2:0]     r_refresh_idx;
  logic [3:0]     r_digit_code;
  logic [7:0]     r_anode;
  logic           r_frame_done;
  logic           r_load_ready;

  // Next-state helpers
  logic           w_blank_last;
  logic           w_on_last;
  logic           w_boundary;
  logic           w_accept;
  phase_t         w_phase_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [2:0]     w_idx_nxt;
  logic [31:0]    w_active_nxt;
  logic           w_pending_nxt;
  logic [3:0]     w_bright_eff;
  logic [CW-1:0]  w_thresh;
  logic           w_lit;
  logic           w_frame_done_nxt;

  always_comb begin
    w_blank_last = (r_phase == PH_BLANK) && (r_cnt == BLANK_LAST);
    w_on_last    = (r_phase == PH_ON) && (r_cnt == ON_LAST);
    w_boundary   = w_on_last && (r_refresh_idx == 3'd7);
    w_accept     = io_load.load_valid && r_load_ready;

    w_phase_nxt  = r_phase;
    w_cnt_nxt    = r_cnt + CW'(1);
    w_idx_nxt    = r_refresh_idx;
    if (w_blank_last) begin
      w_phase_nxt = PH_ON;
      w_cnt_nxt   = '0;
    end else if (w_on_last) begin
      w_phase_nxt = PH_BLANK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = r_refresh_idx + 3'd1;
    end

    // Shadow moves to active only on the frame boundary, and only if it
    // held a value before this cycle; a same-cycle accept waits a frame.
    w_active_nxt  = (w_boundary && r_pending) ? r_shadow : r_active;
    w_pending_nxt = w_accept || (r_pending && !w_boundary);

    // The anode for the first ON cycle is computed on the edge that enters
    // ON, so brightness is taken straight from the input on that edge and
    // from the latched copy for the rest of the phase.
    w_bright_eff = w_blank_last ? i_brightness : r_bright;
    w_thresh     = CW'(STEP * (int'(w_bright_eff) + 1));
    w_lit        = (w_phase_nxt == PH_ON) && i_digit_en[w_idx_nxt] &&
                   ((w_bright_eff == 4'hF) || (w_cnt_nxt < w_thresh));

    w_frame_done_nxt = (w_phase_nxt == PH_ON) && (w_cnt_nxt == ON_LAST) &&
                       (w_idx_nxt == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase       <= PH_BLANK;
      r_cnt         <= '0;
      r_bright      <= '0;
      r_active      <= '0;
      r_shadow      <= '0;
      r_pending     <= 1'b0;
      r_refresh_idx <= '0;
      r_digit_code  <= '0;
      r_anode       <= 8'hFF;
      r_frame_done  <= 1'b0;
      r_load_ready  <= 1'b1;
    end else begin
      r_phase       <= w_phase_nxt;
      r_cnt         <= w_cnt_nxt;
      r_refresh_idx <= w_idx_nxt;

      if (w_blank_last) begin
        r_bright <= i_brightness;
      end

      if (w_accept) begin
        r_shadow <= io_load.load_data;
      end
      r_pending    <= w_pending_nxt;
      r_load_ready <= !w_pending_nxt;
      r_active     <= w_active_nxt;

      // Slot change: code follows the new index, using the buffer that is
      // valid from this edge on (covers the swap at the frame boundary).
      if (w_on_last) begin
        r_digit_code <= w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
      end

      r_anode      <= w_lit ? ~(8'h01 << w_idx_nxt) : 8'hFF;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign io_load.load_ready = r_load_ready;
  assign o_refresh_idx      = r_refresh_idx;
  assign o_digit_code       = r_digit_code;
  assign o_anode            = r_anode;
  assign o_frame_done       = r_frame_done;

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexed scan sequencer for the 8-digit common-anode 7-segment display.
- Generates the 3-bit digit refresh index and the per-digit 4-bit code for the segment decoder.
- Drives active-low anodes with an inter-digit blanking gap, a per-digit enable mask and 16-level PWM brightness.
- Double-buffers the 32-bit display value through a valid/ready load port, so the shown value only changes at frame boundaries.

Parameters:
- TICKS_PER_DIGIT, 100000, clock cycles per digit slot (1 ms at 100 MHz); frame = 8*TICKS_PER_DIGIT.
- BLANK_TICKS, 2000, cycles at the start of each slot with all anodes off; must be < TICKS_PER_DIGIT.
- Derived: ON_TICKS = TICKS_PER_DIGIT - BLANK_TICKS, must be >= 16; STEP = ON_TICKS/16 (integer floor).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_valid  in  1  new display value offered.
- load_ready  out  1  shadow buffer free; load accepted when load_valid && load_ready.
- load_data  in  32  eight nibbles; nibble i (bits 4i+3:4i) = digit i, digit 0 = rightmost.
- digit_en  in  8  bit i = 1 allows digit i to light; sampled each cycle.
- brightness  in  4  PWM level 0..15; sampled on first ON-phase cycle of each slot.
- refresh_idx  out  3  current digit slot 0..7.
- digit_code  out  4  nibble of active buffer for refresh_idx, to the segment decoder.
- anode  out  8  active-low anode drive; at most one bit low.
- frame_done  out  1  one-cycle pulse on the last cycle of digit 7's slot.

Behaviour:
- Reset values, applied on any clk edge with rst_n=0, including mid-frame:
  - refresh_idx=0, anode=8'hFF, digit_code=0, frame_done=0, load_ready=1.
  - Active buffer=0, shadow buffer empty, phase=BLANK, tick counter=0.
- Phase FSM per slot:
  - BLANK: counter 0..BLANK_TICKS-1, anode=8'hFF. Then ON.
  - ON: counter 0..ON_TICKS-1. Then BLANK of slot refresh_idx+1, wrapping 7->0.
  - No idle state; scanning runs continuously from reset release.
- Slot update: refresh_idx and digit_code are registered and change together on the first BLANK cycle of each slot. digit_code = active[4*refresh_idx+3 : 4*refresh_idx].
- Anode drive in ON, registered:
  - anode[refresh_idx]=0 iff digit_en[refresh_idx]=1 and (brightness_latched==15 or on_cnt < STEP*(brightness_latched+1)).
  - All other anode bits are 1.
  - brightness 15 gives full ON_TICKS; level 0 still lights for STEP cycles.
- Load handshake:
  - An accept (load_valid && load_ready) writes the shadow buffer and sets pending; load_ready=0 while pending.
  - A load is never dropped. load_data is don't-care when load_valid=0.
- Frame boundary (last cycle of digit 7's ON phase):
  - frame_done=1 for that cycle.
  - If pending, active<=shadow, pending clears, and load_ready returns to 1 the next cycle.
  - The new value appears from digit 0 of the next frame.
  - A load accepted on the boundary cycle itself is accepted but shown only after the following frame boundary.
- digit_en changes take effect the next cycle. An enable going low mid-ON turns the anode off the next cycle.
- Latency: load accept to first visible digit change is at most 1 frame plus 1 slot.

Test Plan (TICKS_PER_DIGIT=40, BLANK_TICKS=8 -> ON_TICKS=32, STEP=2):
- Reset hold, then release at cycle 0:
  - refresh_idx=0, anode=FF for cycles 0-7.
  - anode=FE for cycles 8-39 (brightness=15, digit_en=FF).
  - refresh_idx=1 at cycle 40; frame_done pulses at cycle 319; refresh_idx wraps to 0 at cycle 320.
- Load 32'h12345678 at cycle 5:
  - load_ready drops at cycle 6 and returns high at cycle 320.
  - digit_code reads 0 during frame 1, then 8,7,6,5,4,3,2,1 across slots 0..7 of frame 2.
- brightness=0: anode low for exactly 2 cycles per slot. brightness=7: low for exactly 16 cycles. Each window begins at ON-phase start.
- digit_en=8'b1010_0101: only slots 0,2,5,7 ever drive a low anode. Clearing bit 0 mid-ON raises anode[0] on the next cycle.
- Second load offered while pending: load_ready=0, so no accept. It is accepted after the boundary and displayed one frame later; first value shown for a full frame.
- Reset asserted at cycle 150 (mid slot 3): next edge gives all reset values; scanning restarts at slot 0 and pending load is discarded.
